// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: scan control, mux select/sample and word handshake bundle
interface mux_scan_sequencer_if #(parameter int SEL_W = 4);
  localparam int N_CH = 2 ** SEL_W;
  logic             start;
  logic             cont;
  logic [SEL_W-1:0] sel;
  logic             mux_out;
  logic [N_CH-1:0]  word;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  modport slave (input start, cont, mux_out, word_ready, output sel, word, word_valid, busy);
  modport master (output start, cont, mux_out, word_ready, input sel, word, word_valid, busy);
endinterface

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks a mux select over all channels and assembles sampled bits into a word
module mux_scan_sequencer #(
  parameter int SEL_W  = 4,
  parameter int SETTLE = 1
) (
  input logic clk,
  input logic rst,
  mux_scan_sequencer_if.slave bus
);
  localparam int N_CH = 2 ** SEL_W;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;
  localparam state_t FIRST = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
  localparam logic [3:0] CNT0 = 4'(SETTLE);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [3:0] cnt_q, cnt_d;
  logic [N_CH-1:0] shadow_q, shadow_d, word_q, word_d;
  logic valid_q, valid_d;
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    word_d   = word_q;
    valid_d  = valid_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        sel_d   = '0;
        cnt_d   = CNT0;
        state_d = FIRST;
      end
      S_SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        shadow_d[sel_q] = bus.mux_out;
        if (sel_q != LAST) begin
          sel_d   = sel_q + SEL_W'(1);
          cnt_d   = CNT0;
          state_d = FIRST;
        end else begin
          // shadow_d already carries the last channel's sample
          word_d  = shadow_d;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: if (bus.word_ready) begin
        valid_d = 1'b0;
        sel_d   = '0;
        cnt_d   = CNT0;
        state_d = bus.cont ? FIRST : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      shadow_q <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end
  assign bus.sel        = sel_q;
  assign bus.word       = word_q;
  assign bus.word_valid = valid_q;
  assign bus.busy       = state_q != S_IDLE;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed checks of scan timing, handshake, continuous mode and reset
module tb_mux_scan_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] pat_a = '0;
  logic [15:0] pat_b = '0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mux_scan_sequencer_if #(.SEL_W(4)) a ();
  mux_scan_sequencer_if #(.SEL_W(4)) b ();
  assign a.mux_out = pat_a[a.sel];
  assign b.mux_out = pat_b[b.sel];
  mux_scan_sequencer #(.SEL_W(4), .SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(a.slave));
  mux_scan_sequencer #(.SEL_W(4), .SETTLE(0)) u0 (.clk(clk), .rst(rst), .bus(b.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] s, input logic [15:0] w,
                       input logic v, input logic bz);
    chk({tag, ".sel"}, 32'(a.sel), 32'(s));
    chk({tag, ".word"}, 32'(a.word), 32'(w));
    chk({tag, ".valid"}, 32'(a.word_valid), 32'(v));
    chk({tag, ".busy"}, 32'(a.busy), 32'(bz));
  endtask

  initial begin
    a.start = 0; a.cont = 0; a.word_ready = 1;
    b.start = 0; b.cont = 0; b.word_ready = 1;
    step(); step();
    chk_a("reset", 4'd0, 16'h0, 1'b0, 1'b0);
    chk("reset_b.busy", 32'(b.busy), 32'd0);
    rst = 0;

    // 1: single scan, SETTLE=1
    pat_a = 16'hA5C3;
    a.start = 1; step(); a.start = 0;
    for (int j = 0; j < 32; j++) begin
      chk("t1.sel", 32'(a.sel), 32'(j / 2));
      chk("t1.valid", 32'(a.word_valid), 32'd0);
      chk("t1.busy", 32'(a.busy), 32'd1);
      step();
    end
    chk_a("t1.done", 4'd15, 16'hA5C3, 1'b1, 1'b1);
    step();
    chk_a("t1.idle", 4'd0, 16'hA5C3, 1'b0, 1'b0);

    // 2: backpressure
    a.word_ready = 0;
    a.start = 1; step(); a.start = 0;
    repeat (32) step();
    for (int j = 0; j < 10; j++) begin
      chk_a("t2.hold", 4'd15, 16'hA5C3, 1'b1, 1'b1);
      step();
    end
    a.word_ready = 1; step();
    chk_a("t2.release", 4'd0, 16'hA5C3, 1'b0, 1'b0);

    // 3: continuous mode, pattern change before ch0 of scan 2
    pat_a = 16'h0001; a.cont = 1;
    a.start = 1; step(); a.start = 0;
    repeat (32) step();
    chk_a("t3.word1", 4'd15, 16'h0001, 1'b1, 1'b1);
    step();
    chk_a("t3.restart", 4'd0, 16'h0001, 1'b0, 1'b1);
    pat_a = 16'h8000; a.cont = 0;
    repeat (32) step();
    chk_a("t3.word2", 4'd15, 16'h8000, 1'b1, 1'b1);
    step();
    chk_a("t3.idle", 4'd0, 16'h8000, 1'b0, 1'b0);

    // 4: reset mid-scan at sel=7
    pat_a = 16'hA5C3;
    a.start = 1; step(); a.start = 0;
    repeat (14) step();
    chk("t4.sel7", 32'(a.sel), 32'd7);
    rst = 1; step(); rst = 0;
    chk_a("t4.reset", 4'd0, 16'h0, 1'b0, 1'b0);
    a.start = 1; step(); a.start = 0;
    repeat (31) step();
    chk("t4.not_yet", 32'(a.word_valid), 32'd0);
    step();
    chk_a("t4.done", 4'd15, 16'hA5C3, 1'b1, 1'b1);
    step();

    // 5: rst+start together, then start pulses while busy
    pat_a = 16'h3C5A;
    rst = 1; a.start = 1; step(); rst = 0; a.start = 0; step();
    chk_a("t5.rst_start", 4'd0, 16'h0, 1'b0, 1'b0);
    a.start = 1; step(); a.start = 0;
    repeat (10) step();
    a.start = 1; step(); a.start = 0;
    chk("t5.sel", 32'(a.sel), 32'd5);
    repeat (20) step();
    chk("t5.not_yet", 32'(a.word_valid), 32'd0);
    a.start = 1; step(); a.start = 0;
    chk_a("t5.done", 4'd15, 16'h3C5A, 1'b1, 1'b1);
    a.start = 1; step(); a.start = 0;
    chk_a("t5.idle", 4'd0, 16'h3C5A, 1'b0, 1'b0);
    step();
    chk("t5.no_restart", 32'(a.busy), 32'd0);

    // 6: SETTLE=0 build
    pat_b = 16'hFFFF;
    b.start = 1; step(); b.start = 0;
    for (int j = 0; j < 16; j++) begin
      chk("t6.sel", 32'(b.sel), 32'(j));
      chk("t6.valid", 32'(b.word_valid), 32'd0);
      step();
    end
    chk("t6.valid_hi", 32'(b.word_valid), 32'd1);
    chk("t6.word", 32'(b.word), 32'hFFFF);
    step();
    chk("t6.idle", 32'(b.busy), 32'd0);
    chk("t6.word_keep", 32'(b.word), 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
